// File: rtl/level_shift_stream_if.sv
// Handshake bundle for level_shift_stream: input beat side, output beat side and
// the saturation statistics controls.
interface level_shift_stream_if #(
  parameter int DATA_W = 8,
  parameter int CH     = 3,
  parameter int IN_W   = 11
);
  logic                   mode;
  logic                   in_valid;
  logic                   in_ready;
  logic [CH*IN_W-1:0]     in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [CH*DATA_W-1:0]   out_data;
  logic                   out_last;
  logic                   out_sat;
  logic [15:0]            sat_cnt;
  logic                   cnt_clr;

  modport slave (
    input  mode, in_valid, in_data, out_ready, cnt_clr,
    output in_ready, out_valid, out_data, out_last, out_sat, sat_cnt
  );

  modport master (
    output mode, in_valid, in_data, out_ready, cnt_clr,
    input  in_ready, out_valid, out_data, out_last, out_sat, sat_cnt
  );
endinterface

// File: rtl/level_shift_stream.sv
// Streaming level shifter over CH lanes: forward (unsigned -> signed) or inverse
// (signed -> clamped unsigned), 2-stage valid/ready pipeline with block marking.
module level_shift_stream #(
  parameter int DATA_W  = 8,
  parameter int CH      = 3,
  parameter int IN_W    = 11,
  parameter int BLK_LEN = 64
) (
  input logic                 clk,
  input logic                 rst,
  level_shift_stream_if.slave bus
);
  localparam int BLK_W = $clog2(BLK_LEN);
  localparam int NS_W  = $clog2(CH + 1);
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (DATA_W - 1);
  localparam logic signed [IN_W:0] MAXV = ((IN_W+1)'(1) << DATA_W) - (IN_W+1)'(1);

  function automatic logic [DATA_W-1:0] fwd_shift(input logic [DATA_W-1:0] x);
    return {~x[DATA_W-1], x[DATA_W-2:0]};
  endfunction

  // Returns {sat, value}; t is one bit wider than the input so the offset cannot overflow.
  function automatic logic [DATA_W:0] inv_clamp(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] t;
    t = {x[IN_W-1], x} + HALF;
    if (t < 0)
      return {1'b1, {DATA_W{1'b0}}};
    else if (t > MAXV)
      return {1'b1, {DATA_W{1'b1}}};
    else
      return {1'b0, t[DATA_W-1:0]};
  endfunction

  function automatic logic [NS_W-1:0] pop_sat(input logic [CH-1:0] s);
    logic [NS_W-1:0] n;
    n = '0;
    for (int k = 0; k < CH; k++) n = n + NS_W'(s[k]);
    return n;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [NS_W-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic                 vld_p1_q, vld_p2_q;
  logic                 mode_p1_q;
  logic [CH*IN_W-1:0]   lanes_p1_q;
  logic [CH*DATA_W-1:0] data_p2_q, data_p2_d;
  logic [CH-1:0]        sat_p2_q, sat_p2_d;
  logic                 out_sat_q;
  logic [15:0]          sat_cnt_q, sat_cnt_d;
  logic [BLK_W-1:0]     blk_cnt_q, blk_cnt_d;
  logic                 s1_load, s2_load, out_hs;

  assign s2_load = !vld_p2_q || bus.out_ready;
  assign s1_load = !vld_p1_q || s2_load;
  assign out_hs  = vld_p2_q && bus.out_ready;

  always_comb begin
    data_p2_d = '0;
    sat_p2_d  = '0;
    for (int k = 0; k < CH; k++) begin
      if (mode_p1_q)
        {sat_p2_d[k], data_p2_d[k*DATA_W +: DATA_W]} = inv_clamp(lanes_p1_q[k*IN_W +: IN_W]);
      else
        data_p2_d[k*DATA_W +: DATA_W] = fwd_shift(lanes_p1_q[k*IN_W +: DATA_W]);
    end
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    blk_cnt_d = blk_cnt_q;
    if (bus.cnt_clr)
      sat_cnt_d = '0;
    else if (out_hs)
      sat_cnt_d = sat_add(sat_cnt_q, pop_sat(sat_p2_q));
    if (out_hs)
      blk_cnt_d = (blk_cnt_q == BLK_W'(BLK_LEN - 1)) ? '0 : blk_cnt_q + 1'b1;
  end

  // Stage 1: capture the lanes together with the mode they were issued under
  always_ff @(posedge clk) begin
    if (rst)
      vld_p1_q <= 1'b0;
    else if (s1_load)
      vld_p1_q <= bus.in_valid;
    if (s1_load && bus.in_valid) begin
      lanes_p1_q <= bus.in_data;
      mode_p1_q  <= bus.mode;
    end
  end

  // Stage 2: shifted/clamped result, sat flags and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      sat_p2_q  <= '0;
      out_sat_q <= 1'b0;
      sat_cnt_q <= '0;
      blk_cnt_q <= '0;
    end else begin
      if (s2_load)
        vld_p2_q <= vld_p1_q;
      if (s2_load && vld_p1_q) begin
        data_p2_q <= data_p2_d;
        sat_p2_q  <= sat_p2_d;
        out_sat_q <= |sat_p2_d;
      end
      sat_cnt_q <= sat_cnt_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = vld_p2_q;
  assign bus.out_data  = data_p2_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_last  = vld_p2_q && (blk_cnt_q == BLK_W'(BLK_LEN - 1));
  assign bus.sat_cnt   = sat_cnt_q;
endmodule

// File: tb/tb_level_shift_stream.sv
// Randomized scoreboard bench for level_shift_stream: driver pushes expected beats,
// monitor pops and compares on every output handshake.
module tb_level_shift_stream;
  localparam int DATA_W  = 8;
  localparam int CH      = 3;
  localparam int IN_W    = 11;
  localparam int BLK_LEN = 64;

  typedef struct {
    logic [CH*DATA_W-1:0] data;
    int                   nsat;
  } exp_t;

  logic clk, rst;
  level_shift_stream_if #(.DATA_W(DATA_W), .CH(CH), .IN_W(IN_W)) bus ();

  level_shift_stream #(.DATA_W(DATA_W), .CH(CH), .IN_W(IN_W), .BLK_LEN(BLK_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   last_pos[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   model_cnt = 0;
  int   hs_cnt = 0;
  int   rdy_mode = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic straight from the shift/clamp rules.
  function automatic exp_t model(input logic m, input logic [CH*IN_W-1:0] d);
    exp_t e;
    int x, r;
    e.data = '0;
    e.nsat = 0;
    for (int k = 0; k < CH; k++) begin
      x = int'(d[k*IN_W +: IN_W]);
      if (!m) begin
        r = (x % (1 << DATA_W)) - (1 << (DATA_W - 1));
      end else begin
        if (x >= (1 << (IN_W - 1))) x = x - (1 << IN_W);
        r = x + (1 << (DATA_W - 1));
        if (r < 0) begin
          r = 0;
          e.nsat++;
        end else if (r > (1 << DATA_W) - 1) begin
          r = (1 << DATA_W) - 1;
          e.nsat++;
        end
      end
      e.data[k*DATA_W +: DATA_W] = r[DATA_W-1:0];
    end
    return e;
  endfunction

  function automatic logic [CH*IN_W-1:0] pk(input int a, input int b, input int c);
    return {c[IN_W-1:0], b[IN_W-1:0], a[IN_W-1:0]};
  endfunction

  function automatic logic [CH*IN_W-1:0] rnd_lanes();
    logic [63:0] rr;
    rr = {$urandom(), $urandom()};
    return rr[CH*IN_W-1:0];
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic m, input logic [CH*IN_W-1:0] d);
    int g;
    g = 0;
    @(posedge clk);
    #1;
    bus.mode     = m;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      chk("in_ready", 64'(bus.in_ready), 64'(!(sb.size() == 2 && !bus.out_ready)));
      if (bus.in_ready) begin
        sb.push_back(model(m, d));
        break;
      end
      g++;
      if (g > 500) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: got no acceptance in 500 cycles, required acceptance");
        break;
      end
    end
  endtask

  task automatic drop();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    if (n > 0) begin
      drop();
      repeat (n - 1) @(posedge clk);
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    @(negedge clk);
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic one(input string nm, input logic m, input logic [CH*IN_W-1:0] d,
                     input logic [CH*DATA_W-1:0] ed, input logic es);
    send(m, d);
    drop();
    @(negedge clk);
    chk({nm, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk({nm, "_lat2_valid"}, 64'(bus.out_valid), 64'd1);
    chk({nm, "_data"}, 64'(bus.out_data), 64'(ed));
    chk({nm, "_sat"}, 64'(bus.out_sat), 64'(es));
  endtask

  // Monitor: pops the scoreboard on each output handshake and tracks statistics.
  initial begin
    exp_t e;
    logic stall_prev;
    logic [CH*DATA_W-1:0] h_data;
    logic h_last, h_sat, hs;
    int   nadd;
    stall_prev = 1'b0;
    h_data = '0;
    h_last = 1'b0;
    h_sat  = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        sb.delete();
        last_pos.delete();
        model_cnt  = 0;
        hs_cnt     = 0;
        stall_prev = 1'b0;
        continue;
      end
      chk("sat_cnt", 64'(bus.sat_cnt), 64'(model_cnt));
      if (stall_prev) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_data", 64'(bus.out_data), 64'(h_data));
        chk("stall_last", 64'(bus.out_last), 64'(h_last));
        chk("stall_sat", 64'(bus.out_sat), 64'(h_sat));
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      h_data = bus.out_data;
      h_last = bus.out_last;
      h_sat  = bus.out_sat;
      hs   = bus.out_valid && bus.out_ready;
      nadd = 0;
      if (hs) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got output %0h, required no output", bus.out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e.data));
          chk("out_sat", 64'(bus.out_sat), 64'(e.nsat != 0));
          chk("out_last", 64'(bus.out_last), 64'((hs_cnt % BLK_LEN) == BLK_LEN - 1));
          nadd = e.nsat;
        end
        if (bus.out_last) last_pos.push_back(hs_cnt + 1);
        hs_cnt++;
      end
      if (bus.cnt_clr)
        model_cnt = 0;
      else if (hs)
        model_cnt = (model_cnt + nadd > 65535) ? 65535 : model_cnt + nadd;
    end
  end

  initial begin
    rst          = 1'b1;
    bus.mode     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.cnt_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_out_sat", 64'(bus.out_sat), 64'd0);
    chk("rst_sat_cnt", 64'(bus.sat_cnt), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed forward and inverse beats
    one("fwd", 1'b0, pk(0, 128, 255), 24'h7F0080, 1'b0);
    one("inv_ok", 1'b1, pk(-128, 0, 127), 24'hFF8000, 1'b0);
    one("inv_clamp", 1'b1, pk(-1024, 1023, -129), 24'h00FF00, 1'b1);
    @(negedge clk);
    chk("sat_cnt_3", 64'(bus.sat_cnt), 64'd3);
    bus.cnt_clr = 1'b1;
    one("clr_beat", 1'b1, pk(-1024, -1024, -1024), 24'h000000, 1'b1);
    @(posedge clk);
    #1;
    bus.cnt_clr = 1'b0;
    @(negedge clk);
    chk("sat_cnt_clr", 64'(bus.sat_cnt), 64'd0);

    // Random backpressure and input gaps
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) begin
      gap($urandom_range(0, 2));
      send(1'($urandom_range(0, 1)), rnd_lanes());
    end
    drop();
    wait_drain();
    rdy_mode = 0;

    // Block marking across a mid-block mode toggle
    do_reset();
    for (int i = 1; i <= 130; i++) send((i >= 40) ? 1'b1 : 1'b0, rnd_lanes());
    drop();
    wait_drain();
    chk("blk_n_last", 64'(last_pos.size()), 64'd2);
    if (last_pos.size() == 2) begin
      chk("blk_last_pos0", 64'(last_pos[0]), 64'd64);
      chk("blk_last_pos1", 64'(last_pos[1]), 64'd128);
    end

    // Saturation counter ceiling
    do_reset();
    for (int i = 0; i < 21844; i++) send(1'b1, pk(-1024, -1024, -1024));
    send(1'b1, pk(-1024, -1024, 0));
    drop();
    wait_drain();
    chk("sat_cnt_fffe", 64'(bus.sat_cnt), 64'hFFFE);
    send(1'b1, pk(1023, -1024, 1023));
    drop();
    wait_drain();
    chk("sat_cnt_ffff", 64'(bus.sat_cnt), 64'hFFFF);
    send(1'b1, pk(-1024, 1023, -1024));
    drop();
    wait_drain();
    chk("sat_cnt_hold", 64'(bus.sat_cnt), 64'hFFFF);

    // Reset with both stages full and the output stalled
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    send(1'b0, rnd_lanes());
    send(1'b1, pk(-1024, 0, 0));
    drop();
    @(negedge clk);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_out_valid", 64'(bus.out_valid), 64'd1);
    rdy_mode = 0;
    do_reset();
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_last", 64'(bus.out_last), 64'd0);
    chk("mid_rst_sat_cnt", 64'(bus.sat_cnt), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    one("post_rst", 1'b0, pk(200, 0, 64), 24'hC08048, 1'b0);
    chk("post_rst_last", 64'(bus.out_last), 64'd0);
    for (int i = 0; i < BLK_LEN - 1; i++) send(1'b0, rnd_lanes());
    drop();
    wait_drain();
    chk("post_rst_n_last", 64'(last_pos.size()), 64'd1);
    if (last_pos.size() == 1) chk("post_rst_last_pos", 64'(last_pos[0]), 64'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
